regfile_wport_arb: RTL and testbench
====================================

REGFILE_WPORT_ARB -- requirements
Module: regfile_wport_arb

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port p_we  input  1  primary (pipeline writeback) write request.
REQ-004 SHALL have port p_addr  input  5  primary destination register.
REQ-005 SHALL have port p_data  input  32  primary write data.
REQ-006 SHALL have port s_valid  input  1  secondary (mul/div/cp0 result) request valid.
REQ-007 SHALL have port s_addr  input  5  secondary destination register.
REQ-008 SHALL have port s_data  input  32  secondary write data.
REQ-009 SHALL have port s_ready  output  1  secondary request accepted this cycle when high with s_valid.
REQ-010 SHALL have ports ra1, ra2  input  5 each  pipeline read addresses for pending-write check.
REQ-011 SHALL have ports busy1, busy2  output  1 each  ra1/ra2 matches a queued secondary write.
REQ-012 SHALL have ports we, wa, wd  output  1/5/32  register-file write port drive (WE3/A3/WD3).
REQ-013 SHALL have port stall_req  output  1  registered request to freeze the pipeline for one cycle.
REQ-014 SHALL have port count  output  2  number of queued secondary entries (0..2).

Function
REQ-015 SHALL hold secondary requests in a 2-entry in-order FIFO (head, tail, count).
REQ-016 SHALL drive s_ready = (count != 2), independent of s_valid.
REQ-017 SHALL push on s_valid && s_ready when s_addr != 0; s_addr == 0 SHALL be accepted and discarded (no push).
REQ-018 SHALL treat p_we with p_addr == 0 as no primary request.
REQ-019 SHALL grant, combinationally, in order: FIFO head if stall_req == 1 and count != 0; else primary if valid; else FIFO head if count != 0; else no write.
REQ-020 SHALL drive we=1, wa/wd from the granted source; we=0 with wa=0, wd=0 when no grant.
REQ-021 SHALL pop the FIFO head at the rising edge ending a cycle in which it was granted.
REQ-022 SHALL, on simultaneous push and pop, keep count unchanged and preserve order (new entry behind remaining entry).
REQ-023 SHALL NOT consume a primary request while stall_req == 1; the pipeline holds p_we/p_addr/p_data stable across the stall.
REQ-024 SHALL assert busyN when raN != 0 and raN equals the address of any valid FIFO entry; busyN=0 for raN == 0.
REQ-025 SHALL keep a 2-bit starve counter: increment (saturating at 3) each cycle count != 0 and head not granted; clear on any pop or when count == 0.
REQ-026 SHALL set stall_req=1 at the edge where the starve counter equals 3 and the head is again not granted; stall_req SHALL clear at the next edge (one-cycle pulse).
REQ-027 SHALL never write register 0 (we=0 whenever the selected address would be 0).

Reset
REQ-028 SHALL, while rst == 0, force count=0, FIFO entries invalid, starve counter 0, stall_req=0, we=0, wa=0, wd=0, busy1=busy2=0, s_ready=0.
REQ-029 SHALL, on reset asserted mid-operation, discard all queued entries; first cycle after release: count=0, s_ready=1.

Verification
REQ-030 Primary only: p_we=1, p_addr=5, p_data=0x1234, FIFO empty -> we=1, wa=5, wd=0x1234 same cycle, count=0.
REQ-031 Contention: s_valid=1 s_addr=7 s_data=0xAA, then p_we idle -> next cycle count=1, busy1=1 for ra1=7, we=1 wa=7 wd=0xAA, count=0 after edge.
REQ-032 Full: two secondary pushes (addr 3, 4) with continuous primary writes -> count=2, s_ready=0, third s_valid held not accepted.
REQ-033 Starvation: count=1, primary writes every cycle -> after 4 ungranted cycles stall_req=1 for exactly one cycle, head written, primary data written the following cycle.
REQ-034 Zero address: s_addr=0 s_valid=1 -> accepted, count stays 0; p_addr=0 p_we=1 -> we=0 unless FIFO head granted.
REQ-035 Reset mid-op: count=2, stall_req=1, rst low -> all outputs zero immediately, count=0 and s_ready=1 after release.

Source files
------------

// File: rtl/regfile_wport_arb.sv
// Register-file write-port arbiter: pipeline writeback vs. a 2-entry queue of
// secondary (mul/div/cp0) results, with starvation-driven one-cycle stall.
module regfile_wport_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_we,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic        s_valid,
  input  logic [4:0]  s_addr,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        stall_req,
  output logic [1:0]  count
);

  logic [4:0]  addr_q [2];
  logic [31:0] data_q [2];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic [1:0]  starve_q, starve_d;
  logic        stall_q, stall_d;

  logic        head_valid;
  logic        p_req;
  logic        push;
  logic        pop;
  logic        grant_head;
  logic        grant_p;
  logic        tail;
  logic [1:0]  slot_vld;

  always_comb begin
    head_valid = (count_q != 2'd0);
    p_req      = p_we && (p_addr != 5'd0);
    s_ready    = rst && (count_q != 2'd2);
    push       = s_valid && s_ready && (s_addr != 5'd0);
    // A pending stall forces the head through even against a primary request.
    grant_head = rst && head_valid && (stall_q || !p_req);
    grant_p    = rst && !(stall_q && head_valid) && p_req;
    pop        = grant_head;
    tail       = head_q ^ count_q[0];

    we = 1'b0;
    wa = '0;
    wd = '0;
    if (grant_head) begin
      we = 1'b1;
      wa = addr_q[head_q];
      wd = data_q[head_q];
    end else if (grant_p) begin
      we = 1'b1;
      wa = p_addr;
      wd = p_data;
    end

    slot_vld[0] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b0));
    slot_vld[1] = (count_q == 2'd2) || ((count_q == 2'd1) && (head_q == 1'b1));
    busy1 = rst && (ra1 != 5'd0) &&
            ((slot_vld[0] && (addr_q[0] == ra1)) || (slot_vld[1] && (addr_q[1] == ra1)));
    busy2 = rst && (ra2 != 5'd0) &&
            ((slot_vld[0] && (addr_q[0] == ra2)) || (slot_vld[1] && (addr_q[1] == ra2)));

    count_d = count_q + {1'b0, push} - {1'b0, pop};
    head_d  = head_q ^ pop;

    starve_d = starve_q;
    if (pop || !head_valid) begin
      starve_d = '0;
    end else if (starve_q != 2'd3) begin
      starve_d = starve_q + 2'd1;
    end

    stall_d = head_valid && !grant_head && (starve_q == 2'd3);

    stall_req = stall_q;
    count     = count_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q   <= 1'b0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q   <= head_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      if (push) begin
        addr_q[tail] <= s_addr;
        data_q[tail] <= s_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb; secondary writes are checked in order
// against a scoreboard filled as requests are driven.
module tb_regfile_wport_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_addr;
  logic [31:0] p_data;
  logic        s_valid;
  logic [4:0]  s_addr;
  logic [31:0] s_data;
  logic        s_ready;
  logic [4:0]  ra1, ra2;
  logic        busy1, busy2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        stall_req;
  logic [1:0]  count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [36:0] sb_q [$];

  regfile_wport_arb dut (
    .clk       (clk),
    .rst       (rst),
    .p_we      (p_we),
    .p_addr    (p_addr),
    .p_data    (p_data),
    .s_valid   (s_valid),
    .s_addr    (s_addr),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .ra1       (ra1),
    .ra2       (ra2),
    .busy1     (busy1),
    .busy2     (busy2),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .stall_req (stall_req),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [4:0] a, input logic [31:0] d);
    sb_q.push_back({a, d});
  endtask

  // Expect the DUT to be writing the oldest outstanding secondary result now.
  task automatic expect_sec(input string tag);
    logic [36:0] e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_we"}, 32'(we), 32'd1);
      check_eq({tag, "_wa"}, 32'(wa), 32'(e[36:32]));
      check_eq({tag, "_wd"}, wd, e[31:0]);
    end
  endtask

  task automatic expect_prim(input string tag, input logic [4:0] a, input logic [31:0] d);
    check_eq({tag, "_we"}, 32'(we), 32'd1);
    check_eq({tag, "_wa"}, 32'(wa), 32'(a));
    check_eq({tag, "_wd"}, wd, d);
  endtask

  initial begin
    bit seen;
    rst = 1'b0; p_we = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
    s_valid = 1'b1; s_addr = 5'd6; s_data = 32'h66; ra1 = 5'd6; ra2 = 5'd5;

    // Reset: outputs forced low even with live requests.
    #2;
    check_eq("rst_we", 32'(we), 32'd0);
    check_eq("rst_wa", 32'(wa), 32'd0);
    check_eq("rst_wd", wd, 32'd0);
    check_eq("rst_sready", 32'(s_ready), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_stall", 32'(stall_req), 32'd0);
    check_eq("rst_busy1", 32'(busy1), 32'd0);
    s_valid = 1'b0; p_we = 1'b0; ra1 = '0; ra2 = '0;
    #10 rst = 1'b1;

    // Primary only.
    cyc();
    p_we = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
    #1;
    check_eq("a_sready", 32'(s_ready), 32'd1);
    check_eq("a_count", 32'(count), 32'd0);
    expect_prim("a", 5'd5, 32'h1234);

    // Secondary with idle primary.
    cyc();
    p_we = 1'b0; s_valid = 1'b1; s_addr = 5'd7; s_data = 32'hAA;
    #1;
    check_eq("b0_we", 32'(we), 32'd0);
    sb_push(5'd7, 32'hAA);
    cyc();
    s_valid = 1'b0; ra1 = 5'd7;
    #1;
    check_eq("b1_count", 32'(count), 32'd1);
    check_eq("b1_busy1", 32'(busy1), 32'd1);
    check_eq("b1_busy2", 32'(busy2), 32'd0);
    expect_sec("b1");
    cyc();
    #1;
    check_eq("b2_count", 32'(count), 32'd0);
    check_eq("b2_busy1", 32'(busy1), 32'd0);
    check_eq("b2_we", 32'(we), 32'd0);

    // Fill under continuous primary, starvation stall, then drain.
    p_we = 1'b1; p_addr = 5'd10; p_data = 32'h1010;
    s_valid = 1'b1; s_addr = 5'd3; s_data = 32'h33;
    #1;
    expect_prim("c0", 5'd10, 32'h1010);
    sb_push(5'd3, 32'h33);
    cyc();
    s_addr = 5'd4; s_data = 32'h44;
    #1;
    check_eq("c1_count", 32'(count), 32'd1);
    expect_prim("c1", 5'd10, 32'h1010);
    sb_push(5'd4, 32'h44);
    cyc();
    s_addr = 5'd5; s_data = 32'h55; ra1 = 5'd3; ra2 = 5'd4;
    #1;
    check_eq("c2_count", 32'(count), 32'd2);
    check_eq("c2_sready", 32'(s_ready), 32'd0);
    check_eq("c2_busy1", 32'(busy1), 32'd1);
    check_eq("c2_busy2", 32'(busy2), 32'd1);
    cyc(); #1;
    check_eq("c3_count", 32'(count), 32'd2);
    check_eq("c3_stall", 32'(stall_req), 32'd0);
    cyc(); #1;
    check_eq("c4_stall", 32'(stall_req), 32'd0);
    expect_prim("c4", 5'd10, 32'h1010);
    cyc(); #1;
    check_eq("c5_stall", 32'(stall_req), 32'd1);
    check_eq("c5_sready", 32'(s_ready), 32'd0);
    expect_sec("c5");
    cyc(); #1;
    check_eq("c6_stall", 32'(stall_req), 32'd0);
    check_eq("c6_count", 32'(count), 32'd1);
    check_eq("c6_sready", 32'(s_ready), 32'd1);
    expect_prim("c6", 5'd10, 32'h1010);
    sb_push(5'd5, 32'h55);
    cyc();
    s_valid = 1'b0; p_we = 1'b0;
    #1;
    check_eq("c7_count", 32'(count), 32'd2);
    expect_sec("c7");
    cyc(); #1;
    check_eq("c8_count", 32'(count), 32'd1);
    expect_sec("c8");
    cyc(); #1;
    check_eq("c9_count", 32'(count), 32'd0);
    check_eq("c9_we", 32'(we), 32'd0);

    // Single queued entry starved by primary: four ungranted cycles, then stall.
    p_we = 1'b1; p_addr = 5'd12; p_data = 32'hC0DE;
    s_valid = 1'b1; s_addr = 5'd9; s_data = 32'h99;
    #1;
    expect_prim("d0", 5'd12, 32'hC0DE);
    sb_push(5'd9, 32'h99);
    cyc();
    s_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check_eq($sformatf("d%0d_stall", i), 32'(stall_req), 32'd0);
      expect_prim($sformatf("d%0d", i), 5'd12, 32'hC0DE);
      cyc();
    end
    #1;
    check_eq("d5_stall", 32'(stall_req), 32'd1);
    expect_sec("d5");
    cyc(); #1;
    check_eq("d6_stall", 32'(stall_req), 32'd0);
    check_eq("d6_count", 32'(count), 32'd0);
    expect_prim("d6", 5'd12, 32'hC0DE);

    // Zero addresses.
    cyc();
    p_we = 1'b1; p_addr = 5'd0; p_data = 32'hDEAD;
    s_valid = 1'b1; s_addr = 5'd0; s_data = 32'hFF; ra1 = 5'd0;
    #1;
    check_eq("e0_sready", 32'(s_ready), 32'd1);
    check_eq("e0_we", 32'(we), 32'd0);
    check_eq("e0_wa", 32'(wa), 32'd0);
    check_eq("e0_wd", wd, 32'd0);
    cyc();
    s_valid = 1'b0;
    #1;
    check_eq("e1_count", 32'(count), 32'd0);
    check_eq("e1_busy1", 32'(busy1), 32'd0);
    check_eq("e1_we", 32'(we), 32'd0);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset while full and stalling.
    p_we = 1'b1; p_addr = 5'd10; p_data = 32'h1010;
    s_valid = 1'b1; s_addr = 5'd20; s_data = 32'h20;
    cyc();
    s_addr = 5'd21; s_data = 32'h21;
    cyc();
    s_valid = 1'b0; ra1 = 5'd20;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cyc();
      seen = stall_req;
    end
    check_eq("f_stall_seen", 32'(seen), 32'd1);
    check_eq("f_count_full", 32'(count), 32'd2);
    rst = 1'b0;
    #1;
    check_eq("f_rst_we", 32'(we), 32'd0);
    check_eq("f_rst_wa", 32'(wa), 32'd0);
    check_eq("f_rst_wd", wd, 32'd0);
    check_eq("f_rst_count", 32'(count), 32'd0);
    check_eq("f_rst_stall", 32'(stall_req), 32'd0);
    check_eq("f_rst_sready", 32'(s_ready), 32'd0);
    check_eq("f_rst_busy1", 32'(busy1), 32'd0);
    p_we = 1'b0;
    cyc();
    rst = 1'b1;
    cyc(); #1;
    check_eq("f_post_count", 32'(count), 32'd0);
    check_eq("f_post_sready", 32'(s_ready), 32'd1);
    check_eq("f_post_we", 32'(we), 32'd0);
    check_eq("f_post_busy1", 32'(busy1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
